// File: rtl/vdc_blitter.sv
// vdc_blitter: block-transfer engine for the VDC CPU data path.
// Performs single READ, single WRITE, FILL and COPY operations on VDC RAM,
// using only the RAM slots the slot scheduler offers.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, mode, dir      command strobe, operation (0=RD 1=WR 2=FILL 3=COPY),
//                         address direction (0=increment, 1=decrement)
//   wc_in, ua_in, ba_in,  word count, update address, block (source) address
//   wda_in                and write/fill data, all latched on an accepted start
//   abort                 terminate the current operation
//   slot, slot_done       slot offer / end of slot with ram_do valid
//   ram_do                RAM read data
//   ram_rd, ram_we,       one-cycle RAM strobes with registered address and
//   ram_addr, ram_di      write data
//   ua, ba, da, wc_left   current update/block address, data reg, words left
//   busy, done            operation in progress / one-cycle completion pulse
module vdc_blitter #(
  parameter int ADDR_BITS = 16,
  parameter int WC_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 dir,
  input  logic [WC_BITS-1:0]   wc_in,
  input  logic [ADDR_BITS-1:0] ua_in,
  input  logic [ADDR_BITS-1:0] ba_in,
  input  logic [7:0]           wda_in,
  input  logic                 abort,
  input  logic                 slot,
  input  logic                 slot_done,
  input  logic [7:0]           ram_do,
  output logic                 ram_rd,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  output logic [ADDR_BITS-1:0] ua,
  output logic [ADDR_BITS-1:0] ba,
  output logic [7:0]           da,
  output logic [WC_BITS-1:0]   wc_left,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_COPYR = 3'd4,
    S_COPYW = 3'd5
  } state_t;

  state_t                 r_state, w_state;
  logic                   r_pending, w_pending;
  logic                   r_aborting, w_aborting;
  logic                   r_dir, w_dir;
  logic [ADDR_BITS-1:0]   r_ua, w_ua, r_ba, w_ba, r_ram_addr, w_ram_addr;
  logic [7:0]             r_da, w_da, r_cda, w_cda, r_wda, w_wda, r_ram_di, w_ram_di;
  logic [WC_BITS-1:0]     r_wc, w_wc;
  logic                   r_ram_rd, w_ram_rd, r_ram_we, w_ram_we;
  logic                   r_busy, w_busy, r_done, w_done;

  logic [ADDR_BITS-1:0]   w_step;
  logic [WC_BITS-1:0]     w_wc_dec;
  logic                   w_wc_last;
  logic                   w_complete;
  logic                   w_issue;

  // +1 or -1 modulo 2^ADDR_BITS; word counter wraps so wc=0 means 2^WC_BITS
  assign w_step     = r_dir ? {ADDR_BITS{1'b1}} : {{(ADDR_BITS-1){1'b0}}, 1'b1};
  assign w_wc_dec   = r_wc - {{(WC_BITS-1){1'b0}}, 1'b1};
  assign w_wc_last  = (r_wc == {{(WC_BITS-1){1'b0}}, 1'b1});
  assign w_complete = r_pending & slot_done;
  // A slot coinciding with slot_done is never used for a new access
  assign w_issue    = (r_state != S_IDLE) & slot & ~slot_done & ~r_pending & ~r_aborting & ~abort;

  // Next-state and datapath update logic
  always_comb begin
    w_state    = r_state;
    w_pending  = r_pending;
    w_aborting = r_aborting;
    w_dir      = r_dir;
    w_ua       = r_ua;
    w_ba       = r_ba;
    w_da       = r_da;
    w_cda      = r_cda;
    w_wda      = r_wda;
    w_wc       = r_wc;
    w_ram_addr = r_ram_addr;
    w_ram_di   = r_ram_di;
    w_ram_rd   = 1'b0;
    w_ram_we   = 1'b0;

    if (r_state == S_IDLE) begin
      // Abort in idle is ignored, but it also cancels a coincident start
      if (start && !abort) begin
        w_ua  = ua_in;
        w_ba  = ba_in;
        w_wda = wda_in;
        w_wc  = wc_in;
        w_dir = dir;
        case (mode)
          2'd0:    w_state = S_READ;
          2'd1:    w_state = S_WRITE;
          2'd2:    w_state = S_FILL;
          default: w_state = S_COPYR;
        endcase
      end else begin
        w_state = S_IDLE;
      end
    end else if (w_complete) begin
      w_pending = 1'b0;
      case (r_state)
        S_READ: begin
          w_da    = ram_do;
          w_state = S_IDLE;
        end
        S_WRITE: begin
          // A write is followed by a reload of DA from the new UA
          w_ua    = r_ua + w_step;
          w_state = S_READ;
        end
        S_FILL: begin
          w_ua    = r_ua + w_step;
          w_wc    = w_wc_dec;
          w_state = w_wc_last ? S_IDLE : S_FILL;
        end
        S_COPYR: begin
          w_cda   = ram_do;
          w_ba    = r_ba + w_step;
          w_state = S_COPYW;
        end
        S_COPYW: begin
          w_ua    = r_ua + w_step;
          w_wc    = w_wc_dec;
          w_state = w_wc_last ? S_IDLE : S_COPYR;
        end
        default: w_state = S_IDLE;
      endcase
      // Bookkeeping of the in-flight access is kept even when aborting
      if (abort || r_aborting) begin
        w_state = S_IDLE;
      end else begin
        w_aborting = 1'b0;
      end
    end else if (abort) begin
      if (r_pending) begin
        w_aborting = 1'b1;
      end else begin
        w_state = S_IDLE;
      end
    end else if (w_issue) begin
      w_pending = 1'b1;
      case (r_state)
        S_READ: begin
          w_ram_addr = r_ua;
          w_ram_rd   = 1'b1;
        end
        S_WRITE, S_FILL: begin
          w_ram_addr = r_ua;
          w_ram_di   = r_wda;
          w_ram_we   = 1'b1;
        end
        S_COPYR: begin
          w_ram_addr = r_ba;
          w_ram_rd   = 1'b1;
        end
        S_COPYW: begin
          w_ram_addr = r_ua;
          w_ram_di   = r_cda;
          w_ram_we   = 1'b1;
        end
        default: w_pending = 1'b0;
      endcase
    end else begin
      w_state = r_state;
    end

    w_busy = (w_state != S_IDLE);
    w_done = (r_state != S_IDLE) && (w_state == S_IDLE);
    if (w_state == S_IDLE) begin
      w_aborting = 1'b0;
    end else begin
      w_aborting = w_aborting;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_aborting <= 1'b0;
      r_dir      <= 1'b0;
      r_ua       <= {ADDR_BITS{1'b0}};
      r_ba       <= {ADDR_BITS{1'b0}};
      r_da       <= 8'd0;
      r_cda      <= 8'd0;
      r_wda      <= 8'd0;
      r_wc       <= {WC_BITS{1'b0}};
      r_ram_addr <= {ADDR_BITS{1'b0}};
      r_ram_di   <= 8'd0;
      r_ram_rd   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pending  <= w_pending;
      r_aborting <= w_aborting;
      r_dir      <= w_dir;
      r_ua       <= w_ua;
      r_ba       <= w_ba;
      r_da       <= w_da;
      r_cda      <= w_cda;
      r_wda      <= w_wda;
      r_wc       <= w_wc;
      r_ram_addr <= w_ram_addr;
      r_ram_di   <= w_ram_di;
      r_ram_rd   <= w_ram_rd;
      r_ram_we   <= w_ram_we;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign ram_rd   = r_ram_rd;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_di   = r_ram_di;
  assign ua       = r_ua;
  assign ba       = r_ba;
  assign da       = r_da;
  assign wc_left  = r_wc;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
